// File: rtl/lut_pkg.sv
// Shared definitions for the fracturable two-LUT cell write sequencer and its
// readback helpers: FSM state type, command/LUT encodings and width helpers.
package lut_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } seq_state_t;

    localparam logic CMD_CFG    = 1'b0;
    localparam logic CMD_WRITE  = 1'b1;
    localparam logic LUT_FIRST  = 1'b1;
    localparam logic LUT_SECOND = 1'b0;

    // Config word holds both LUT halves plus the split (fracture) bit on top.
    function automatic int cfg_w(input int inputs);
        return 2 * (1 << inputs) + 1;
    endfunction

endpackage

// File: rtl/lut_sxx_addr_map.sv
// Maps a LUT entry index and half select onto the cell's shared address bus.
// Second-half entries skip address bit INPUTS-1 because the cell steers it elsewhere.
module lut_sxx_addr_map
    import lut_pkg::*;
#(
    parameter int INPUTS = 4
) (
    input  logic [INPUTS-1:0]   cnt,
    input  logic                lut_sel,
    output logic [2*INPUTS-1:0] addr
);

    always_comb begin
        addr = '0;
        if (lut_sel == LUT_FIRST) begin
            addr[2*INPUTS-1:INPUTS] = cnt;
        end else begin
            addr[INPUTS]       = cnt[INPUTS-1];
            addr[INPUTS-2:0]   = cnt[INPUTS-2:0];
        end
    end

endmodule

// File: rtl/lut_sxx_write_sequencer.sv
// Sequences config and per-entry user writes into one fracturable two-LUT cell,
// owning the cell address bus while busy and forwarding user_addr while idle.
module lut_sxx_write_sequencer
    import lut_pkg::*;
#(
    parameter  int INPUTS   = 4,
    localparam int MEM_SIZE = 1 << INPUTS,
    localparam int CFG_W    = 2 * MEM_SIZE + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_type,
    input  logic                cmd_lut,
    input  logic [CFG_W-1:0]    cmd_data,
    input  logic [2*INPUTS-1:0] user_addr,
    output logic [2*INPUTS-1:0] lut_addr,
    output logic                lut_cen,
    output logic [CFG_W-1:0]    lut_config,
    output logic                lut_data_in,
    output logic                lut_write_en,
    output logic                lut_write_sel,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                split_q
);

    localparam logic [INPUTS-1:0] CNT_LAST = INPUTS'(MEM_SIZE - 1);

    seq_state_t          state_q, state_d;
    logic [INPUTS-1:0]   cnt_q, cnt_d;
    logic [CFG_W-1:0]    data_q, data_d;
    logic                lut_q, lut_d;
    logic                split_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                cen_q, cen_d;
    logic [CFG_W-1:0]    config_q, config_d;
    logic                din_q, din_d;
    logic                we_q, we_d;
    logic                sel_q, sel_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [2*INPUTS-1:0] addr_q, addr_d;
    logic [2*INPUTS-1:0] map_addr;
    logic [MEM_SIZE-1:0] entries;
    logic                accept;

    assign accept  = cmd_valid && (state_q == ST_IDLE);
    assign entries = data_d[MEM_SIZE-1:0];

    lut_sxx_addr_map #(
        .INPUTS (INPUTS)
    ) u_addr_map (
        .cnt     (cnt_d),
        .lut_sel (lut_d),
        .addr    (map_addr)
    );

    // An unsplit cell drives the second half's top address from out[1], so it cannot be written.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        lut_d   = lut_q;
        split_d = split_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d = cmd_data;
                    lut_d  = cmd_lut;
                    cnt_d  = '0;
                    if (cmd_type == CMD_CFG) begin
                        state_d = ST_CFG;
                    end else if ((cmd_lut == LUT_SECOND) && !split_q) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_CFG: begin
                split_d = data_q[CFG_W-1];
                state_d = ST_DONE;
            end
            ST_WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + INPUTS'(1);
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        ready_d  = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
        cen_d    = (state_d == ST_CFG);
        config_d = cen_d ? data_d : '0;
        we_d     = (state_d == ST_WRITE);
        sel_d    = we_d ? lut_d : 1'b0;
        din_d    = we_d ? entries[cnt_d] : 1'b0;
        addr_d   = we_d ? map_addr : '0;
        done_d   = (state_d == ST_DONE);
        err_d    = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            lut_q    <= 1'b0;
            split_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            cen_q    <= 1'b0;
            config_q <= '0;
            din_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            lut_q    <= lut_d;
            split_q  <= split_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            cen_q    <= cen_d;
            config_q <= config_d;
            din_q    <= din_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
        end
    end

    assign cmd_ready     = ready_q;
    assign busy          = busy_q;
    assign lut_cen       = cen_q;
    assign lut_config    = config_q;
    assign lut_data_in   = din_q;
    assign lut_write_en  = we_q;
    assign lut_write_sel = sel_q;
    assign done          = done_q;
    assign err           = err_q;
    assign lut_addr      = (state_q == ST_IDLE) ? user_addr : addr_q;

endmodule
